pc_seq_unit: RTL and testbench

//  Parametrised next-PC sequencer for the multicycle MIPS core. Owns the PC register, EPC and EXL

---
 rtl/pc_seq_unit_pkg.sv | 50 +++++
 rtl/pc_seq_unit_npc_target.sv | 56 +++++
 rtl/pc_seq_unit.sv | 88 ++++++++
 tb/tb_pc_seq_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_unit_pkg.sv
// Shared encodings and helpers for the next-PC sequencer.
package pc_seq_unit_pkg;

  localparam int unsigned NPC_OP_W   = 3;
  localparam int unsigned BR_COND_W  = 3;
  localparam int unsigned EXC_CODE_W = 5;
  localparam int unsigned IMM_W      = 26;
  localparam int unsigned BR_IMM_W   = 16;

  // Next-PC source selected by the control FSM; codes 5..7 are reserved.
  typedef enum logic [NPC_OP_W-1:0] {
    NPC_PLUS4  = 3'd0,
    NPC_BRANCH = 3'd1,
    NPC_JUMP   = 3'd2,
    NPC_JREG   = 3'd3,
    NPC_ERET   = 3'd4
  } npc_op_e;

  // Conditional branch flavours; codes 6..7 never take the branch.
  typedef enum logic [BR_COND_W-1:0] {
    BR_EQ  = 3'd0,
    BR_NE  = 3'd1,
    BR_LEZ = 3'd2,
    BR_GTZ = 3'd3,
    BR_LTZ = 3'd4,
    BR_GEZ = 3'd5
  } br_cond_e;

  // Exception cause codes reported on exc_cause.
  localparam logic [EXC_CODE_W-1:0] EXC_INT  = 5'd0;
  localparam logic [EXC_CODE_W-1:0] EXC_ADEL = 5'd4;

  // Branch decision from the ALU zero flag and the rs sign bit.
  function automatic logic br_taken(input logic [BR_COND_W-1:0] cond,
                                    input logic zero, input logic neg);
    logic take;
    take = 1'b0;
    case (br_cond_e'(cond))
      BR_EQ:   take = zero;
      BR_NE:   take = !zero;
      BR_LEZ:  take = neg | zero;
      BR_GTZ:  take = !neg & !zero;
      BR_LTZ:  take = neg;
      BR_GEZ:  take = !neg;
      default: take = 1'b0;
    endcase
    return take;
  endfunction

endpackage

// File: rtl/pc_seq_unit_npc_target.sv
// Combinational next-PC candidate and JR/JALR misalignment detection.
module npc_target
  import pc_seq_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0]    pc,
  input  logic [ADDR_W-1:0]    epc,
  input  logic [ADDR_W-1:0]    reg_a,
  input  logic [NPC_OP_W-1:0]  npc_op,
  input  logic [BR_COND_W-1:0] br_cond,
  input  logic                 zero,
  input  logic                 neg,
  input  logic [IMM_W-1:0]     imm26,
  output logic [ADDR_W-1:0]    npc,
  output logic                 misaligned
);

  localparam int unsigned SEXT_W = ADDR_W - BR_IMM_W - 2;

  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] jreg_target;
  logic              take;

  // Candidate targets; all additions wrap modulo 2^ADDR_W.
  always_comb begin
    pc_plus4    = pc + ADDR_W'(4);
    br_off      = {{SEXT_W{imm26[BR_IMM_W-1]}}, imm26[BR_IMM_W-1:0], 2'b00};
    br_target   = pc + br_off;
    jump_target = {pc[ADDR_W-1:28], imm26, 2'b00};
    jreg_target = {reg_a[ADDR_W-1:2], 2'b00};
    take        = br_taken(br_cond, zero, neg);
  end

  // Misalignment only matters for register-indirect jumps.
  always_comb begin
    misaligned = (npc_op == NPC_JREG) && (reg_a[1:0] != 2'b00);
  end

  // Select the next-PC candidate; reserved codes fall back to sequential.
  always_comb begin
    npc = pc_plus4;
    case (npc_op_e'(npc_op))
      NPC_PLUS4:  npc = pc_plus4;
      NPC_BRANCH: npc = take ? br_target : pc_plus4;
      NPC_JUMP:   npc = jump_target;
      NPC_JREG:   npc = jreg_target;
      NPC_ERET:   npc = epc;
      default:    npc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_seq_unit.sv
// Next-PC sequencer: owns PC, EPC, EXL and exception reporting registers.
module pc_seq_unit
  import pc_seq_unit_pkg::*;
#(
  parameter int unsigned          ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC   = ADDR_W'(32'h0000_3000),
  parameter logic [ADDR_W-1:0]    EXC_VECTOR = ADDR_W'(32'h0000_4180),
  parameter int unsigned          CAUSE_W    = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pc_we,
  input  logic [NPC_OP_W-1:0]  npc_op,
  input  logic [BR_COND_W-1:0] br_cond,
  input  logic                 zero,
  input  logic                 neg,
  input  logic [IMM_W-1:0]     imm26,
  input  logic [ADDR_W-1:0]    reg_a,
  input  logic                 exc_req,
  output logic [ADDR_W-1:0]    pc,
  output logic [ADDR_W-1:0]    npc,
  output logic [ADDR_W-1:0]    epc,
  output logic                 exl,
  output logic                 exc_taken,
  output logic [CAUSE_W-1:0]   exc_cause
);

  logic misaligned;
  logic irq_entry;
  logic adel_entry;
  logic eret_commit;

  npc_target #(
    .ADDR_W (ADDR_W)
  ) u_npc_target (
    .pc         (pc),
    .epc        (epc),
    .reg_a      (reg_a),
    .npc_op     (npc_op),
    .br_cond    (br_cond),
    .zero       (zero),
    .neg        (neg),
    .imm26      (imm26),
    .npc        (npc),
    .misaligned (misaligned)
  );

  // Commit decisions in priority order; EXL masks both exception sources.
  always_comb begin
    irq_entry   = exc_req && !exl;
    adel_entry  = !irq_entry && misaligned && !exl;
    eret_commit = !irq_entry && !adel_entry && (npc_op == NPC_ERET);
  end

  // PC/EPC/EXL/cause registers; only an edge with pc_we=1 commits.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      epc       <= '0;
      exl       <= 1'b0;
      exc_taken <= 1'b0;
      exc_cause <= '0;
    end else begin
      exc_taken <= 1'b0;
      if (pc_we) begin
        if (irq_entry) begin
          epc       <= pc;
          pc        <= EXC_VECTOR;
          exl       <= 1'b1;
          exc_taken <= 1'b1;
          exc_cause <= CAUSE_W'(EXC_INT);
        end else if (adel_entry) begin
          epc       <= pc;
          pc        <= EXC_VECTOR;
          exl       <= 1'b1;
          exc_taken <= 1'b1;
          exc_cause <= CAUSE_W'(EXC_ADEL);
        end else if (eret_commit) begin
          pc  <= epc;
          exl <= 1'b0;
        end else begin
          pc <= npc;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_seq_unit.sv
// Self-checking bench for pc_seq_unit: directed steps plus randomized traffic.
module tb_pc_seq_unit;

  localparam logic [2:0] OP_PLUS4  = 3'd0;
  localparam logic [2:0] OP_BRANCH = 3'd1;
  localparam logic [2:0] OP_JUMP   = 3'd2;
  localparam logic [2:0] OP_JREG   = 3'd3;
  localparam logic [2:0] OP_ERET   = 3'd4;
  localparam logic [2:0] C_EQ  = 3'd0;
  localparam logic [2:0] C_GTZ = 3'd3;

  logic        clk = 1'b0;
  logic        rst, pc_we, zero, neg, exc_req;
  logic [2:0]  npc_op, br_cond;
  logic [25:0] imm26;
  logic [31:0] reg_a;
  logic [31:0] pc, npc, epc;
  logic        exl, exc_taken;
  logic [4:0]  exc_cause;

  logic [31:0] m_pc, m_epc;
  logic        m_exl, m_taken;
  logic [4:0]  m_cause;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pc_seq_unit dut (
    .clk       (clk),
    .rst       (rst),
    .pc_we     (pc_we),
    .npc_op    (npc_op),
    .br_cond   (br_cond),
    .zero      (zero),
    .neg       (neg),
    .imm26     (imm26),
    .reg_a     (reg_a),
    .exc_req   (exc_req),
    .pc        (pc),
    .npc       (npc),
    .epc       (epc),
    .exl       (exl),
    .exc_taken (exc_taken),
    .exc_cause (exc_cause)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference next-PC from the architectural rules, using integer arithmetic.
  function automatic logic [31:0] ref_npc(input logic [2:0] op, input logic [2:0] cond,
                                          input logic z, input logic n, input logic [25:0] imm,
                                          input logic [31:0] ra, input logic [31:0] p,
                                          input logic [31:0] e);
    bit take;
    int off;
    case (cond)
      3'd0:    take = z;
      3'd1:    take = !z;
      3'd2:    take = n || z;
      3'd3:    take = !n && !z;
      3'd4:    take = n;
      3'd5:    take = !n;
      default: take = 0;
    endcase
    off = int'($signed(imm[15:0])) * 4;
    case (op)
      3'd1:    return take ? p + 32'(off) : p + 32'd4;
      3'd2:    return (p & 32'hF000_0000) | (32'(imm) << 2);
      3'd3:    return ra & ~32'd3;
      3'd4:    return e;
      default: return p + 32'd4;
    endcase
  endfunction

  // One clock of stimulus: check npc before the edge, registers after it.
  task automatic step(input logic r, input logic we, input logic [2:0] op, input logic [2:0] cond,
                      input logic z, input logic n, input logic [25:0] imm,
                      input logic [31:0] ra, input logic er);
    logic [31:0] e_npc;
    rst = r; pc_we = we; npc_op = op; br_cond = cond; zero = z; neg = n;
    imm26 = imm; reg_a = ra; exc_req = er;
    #2;
    e_npc = ref_npc(op, cond, z, n, imm, ra, m_pc, m_epc);
    if (!r) chk("npc", npc, e_npc);
    @(posedge clk);
    m_taken = 1'b0;
    if (r) begin
      m_pc = 32'h3000; m_epc = 0; m_exl = 0; m_cause = 0;
    end else if (we) begin
      if (er && !m_exl) begin
        m_epc = m_pc; m_pc = 32'h4180; m_exl = 1; m_cause = 0; m_taken = 1;
      end else if (op == OP_JREG && ra[1:0] != 2'b00 && !m_exl) begin
        m_epc = m_pc; m_pc = 32'h4180; m_exl = 1; m_cause = 4; m_taken = 1;
      end else if (op == OP_ERET) begin
        m_pc = m_epc; m_exl = 0;
      end else begin
        m_pc = e_npc;
      end
    end
    #1;
    chk("pc", pc, m_pc);
    chk("epc", epc, m_epc);
    chk("exl", 32'(exl), 32'(m_exl));
    chk("exc_taken", 32'(exc_taken), 32'(m_taken));
    chk("exc_cause", 32'(exc_cause), 32'(m_cause));
  endtask

  task automatic go(input logic [2:0] op, input logic [2:0] cond, input logic z,
                    input logic n, input logic [25:0] imm, input logic [31:0] ra,
                    input logic er);
    step(1'b0, 1'b1, op, cond, z, n, imm, ra, er);
  endtask

  task automatic set_pc(input logic [31:0] a);
    go(OP_JREG, 3'd0, 1'b0, 1'b0, 26'd0, a, 1'b0);
  endtask

  initial begin
    m_pc = 'x; m_epc = 'x; m_exl = 1'bx; m_taken = 1'bx; m_cause = 'x;
    // Reset for two cycles, with commit and request asserted to test override.
    step(1'b1, 1'b1, OP_JUMP, 3'd0, 1'b0, 1'b0, 26'h3FF_FFFF, 32'h1234_5678, 1'b1);
    step(1'b1, 1'b1, OP_JUMP, 3'd0, 1'b0, 1'b0, 26'h3FF_FFFF, 32'h1234_5678, 1'b1);
    chk("rst_pc", pc, 32'h3000);
    go(OP_PLUS4, 3'd0, 1'b0, 1'b0, 26'd0, 32'd0, 1'b0); chk("seq1", pc, 32'h3004);
    go(OP_PLUS4, 3'd0, 1'b0, 1'b0, 26'd0, 32'd0, 1'b0); chk("seq2", pc, 32'h3008);
    go(OP_PLUS4, 3'd0, 1'b0, 1'b0, 26'd0, 32'd0, 1'b0); chk("seq3", pc, 32'h300C);
    go(OP_PLUS4, 3'd0, 1'b0, 1'b0, 26'd0, 32'd0, 1'b0);
    // Branch EQ taken backwards and not taken.
    go(OP_BRANCH, C_EQ, 1'b1, 1'b0, 26'h000FFFF, 32'd0, 1'b0); chk("beq_t", pc, 32'h300C);
    set_pc(32'h3010);
    go(OP_BRANCH, C_EQ, 1'b0, 1'b0, 26'h000FFFF, 32'd0, 1'b0); chk("beq_nt", pc, 32'h3014);
    set_pc(32'h3010);
    go(OP_BRANCH, C_GTZ, 1'b0, 1'b0, 26'h0000004, 32'd0, 1'b0); chk("bgtz_t", pc, 32'h3020);
    // Full condition truth table against the model.
    for (int c = 0; c < 6; c++)
      for (int f = 0; f < 4; f++) begin
        set_pc(32'h3010);
        go(OP_BRANCH, 3'(c), f[0], f[1], 26'h0000004, 32'd0, 1'b0);
      end
    // Jumps.
    set_pc(32'h0040_0000);
    go(OP_JUMP, 3'd0, 1'b0, 1'b0, 26'h0000C10, 32'd0, 1'b0); chk("j", pc, 32'h3040);
    go(OP_JREG, 3'd0, 1'b0, 1'b0, 26'd0, 32'h3100, 1'b0); chk("jr", pc, 32'h3100);
    // Misaligned JR raises AdEL.
    go(OP_JREG, 3'd0, 1'b0, 1'b0, 26'd0, 32'h3102, 1'b0);
    chk("adel_pc", pc, 32'h4180); chk("adel_epc", epc, 32'h3100);
    chk("adel_cause", 32'(exc_cause), 32'd4); chk("adel_taken", 32'(exc_taken), 32'd1);
    go(OP_PLUS4, 3'd0, 1'b0, 1'b0, 26'd0, 32'd0, 1'b1);
    chk("masked_pc", pc, 32'h4184); chk("taken_clr", 32'(exc_taken), 32'd0);
    // Nested misaligned JR commits the aligned target.
    go(OP_JREG, 3'd0, 1'b0, 1'b0, 26'd0, 32'h4187, 1'b0); chk("nest_jr", pc, 32'h4184);
    // ERET beats a pending request while EXL is set; request is taken next.
    go(OP_ERET, 3'd0, 1'b0, 1'b0, 26'd0, 32'd0, 1'b1);
    chk("eret_pc", pc, 32'h3100); chk("eret_exl", 32'(exl), 32'd0);
    go(OP_PLUS4, 3'd0, 1'b0, 1'b0, 26'd0, 32'd0, 1'b1); chk("irq_pc", pc, 32'h4180);
    go(OP_ERET, 3'd0, 1'b0, 1'b0, 26'd0, 32'd0, 1'b0);
    // Request without pc_we is not latched.
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, OP_PLUS4, 3'd0, 1'b0, 1'b0, 26'd0, 32'd0, 1'b1);
    chk("hold_pc", pc, 32'h3100);
    go(OP_PLUS4, 3'd0, 1'b0, 1'b0, 26'd0, 32'd0, 1'b1);
    chk("int_cause", 32'(exc_cause), 32'd0); chk("int_exl", 32'(exl), 32'd1);
    step(1'b1, 1'b1, OP_PLUS4, 3'd0, 1'b0, 1'b0, 26'd0, 32'd0, 1'b1);
    chk("rst2_pc", pc, 32'h3000); chk("rst2_epc", epc, 32'd0);
    // Wrap-around cases.
    set_pc(32'hFFFF_FFFC);
    go(OP_PLUS4, 3'd0, 1'b0, 1'b0, 26'd0, 32'd0, 1'b0); chk("wrap4", pc, 32'h0);
    set_pc(32'h0000_0008);
    go(OP_BRANCH, C_EQ, 1'b1, 1'b0, 26'h000FFF0, 32'd0, 1'b0); chk("wrap_br", pc, 32'hFFFF_FFC8);
    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ra;
      ra = $urandom;
      if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 5)),
           1'($urandom), 1'($urandom), 26'($urandom), ra,
           ($urandom_range(0, 9) == 0));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
